if0_fetch: RTL and testbench

PC generator and instruction-memory request initiator for the front end. It sequences fetch addresses and issues them on the imem request/grant/response interface. It buffers returned instructions with their PCs and hands them to the `if1` pipeline register through a valid/allow handshake. It also absorbs branch redirects by flushing buffered work and discarding in-flight responses.

---
 rtl/if0_fetch_pkg.sv | 21 ++
 rtl/if0_fetch_fifo.sv | 68 ++++++
 rtl/if0_fetch.sv | 135 +++++++++++++
 tb/tb_if0_fetch.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if0_fetch_pkg.sv
// rtl/if0_fetch_pkg.sv - shared constants and types for the if0 fetch stage
package if0_fetch_pkg;

    localparam int RegW = 32;
    localparam logic [RegW-1:0] LOONG_PC_START_ADDR = 32'h1C00_0000;
    localparam logic [RegW-1:0] INST_STEP = 32'd4;

    typedef logic [RegW-1:0] word_t;

    // One buffered instruction as handed to if1
    typedef struct packed {
        word_t pc;
        word_t inst;
    } fetch_entry_t;

    // Sequential fetch address; wraps modulo 2^RegW
    function automatic word_t next_pc(input word_t pc);
        return pc + INST_STEP;
    endfunction

endpackage

// File: rtl/if0_fetch_fifo.sv
// rtl/if0_fetch_fifo.sv - synchronous FIFO with flush, used for tags and fetched instructions
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count == '0);
    assign full_o  = (count == CNT_W'(DEPTH));
    assign count_o = count;
    // A pop frees the slot a simultaneous push needs, so full+pop+push is legal
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    // Head reads as zero when empty so downstream sees clean data
    assign head_o  = empty_o ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush wins over push/pop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage array; contents are only observed through the occupancy-gated head
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

endmodule

// File: rtl/if0_fetch.sv
// rtl/if0_fetch.sv - PC sequencer and imem request/response front end
module if0_fetch
    import if0_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            redirect_valid_i,
    input  logic [RegW-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [RegW-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [RegW-1:0] imem_rdata_i,
    output logic            if_valid_o,
    output logic [RegW-1:0] if_pc_o,
    output logic [RegW-1:0] if_inst_o,
    input  logic            if_allow_i
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(DEPTH);

    word_t            fetch_pc;
    word_t            fetch_pc_d;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] inflight_d;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] discard_d;
    logic [CNT_W-1:0] tag_count;
    logic [CNT_W-1:0] out_count;
    logic             tag_full;
    logic             tag_empty;
    logic             out_full;
    logic             out_empty;
    word_t            tag_head;
    fetch_entry_t     out_push_data;
    fetch_entry_t     out_head;
    logic             grant;
    logic             resp;
    logic             out_push;
    logic             out_pop;
    logic             unused_flags;

    // Credit covers both outstanding requests and buffered instructions, so
    // every response always has a slot waiting for it
    assign imem_req_o  = !redirect_valid_i &&
                         (({1'b0, inflight} + {1'b0, out_count}) < CREDIT_MAX);
    assign imem_addr_o = fetch_pc;
    assign grant       = imem_req_o && imem_gnt_i;
    // A response with nothing outstanding is a protocol error and is ignored
    assign resp        = imem_rvalid_i && (inflight != '0);
    // Responses owed from before a redirect, or arriving during one, are dropped
    assign out_push    = resp && (discard == '0) && !redirect_valid_i;
    assign out_pop     = if_valid_o && if_allow_i;

    assign out_push_data = '{pc: tag_head, inst: imem_rdata_i};
    assign if_valid_o    = !out_empty;
    assign if_pc_o       = out_head.pc;
    assign if_inst_o     = out_head.inst;
    assign unused_flags  = tag_full ^ tag_empty ^ out_full;

    // Addresses of granted requests, consumed in order as responses return
    fetch_fifo #(
        .WIDTH (RegW),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (grant),
        .push_data_i (fetch_pc),
        .pop_i       (resp),
        .flush_i     (1'b0),
        .head_o      (tag_head),
        .count_o     (tag_count),
        .full_o      (tag_full),
        .empty_o     (tag_empty)
    );

    // Fetched {pc, inst} pairs waiting for if1
    fetch_fifo #(
        .WIDTH (2 * RegW),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (out_push),
        .push_data_i (out_push_data),
        .pop_i       (out_pop),
        .flush_i     (redirect_valid_i),
        .head_o      (out_head),
        .count_o     (out_count),
        .full_o      (out_full),
        .empty_o     (out_empty)
    );

    // Next PC, outstanding count and discard count from grant/response/redirect
    always_comb begin
        fetch_pc_d = fetch_pc;
        inflight_d = inflight + CNT_W'(grant) - CNT_W'(resp);
        discard_d  = discard;
        if (grant) begin
            fetch_pc_d = next_pc(fetch_pc);
        end
        if (redirect_valid_i) begin
            fetch_pc_d = redirect_pc_i;
            discard_d  = inflight - CNT_W'(resp);
        end else if (resp && (discard != '0)) begin
            discard_d = discard - 1'b1;
        end
    end

    // Fetch state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc <= LOONG_PC_START_ADDR;
            inflight <= '0;
            discard  <= '0;
        end else begin
            fetch_pc <= fetch_pc_d;
            inflight <= inflight_d;
            discard  <= discard_d;
        end
    end

    // The memory must never answer a request this block did not issue
    a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        imem_rvalid_i |-> (inflight != '0));

    // Every outstanding request owns exactly one tag entry
    a_tag_tracks_inflight: assert property (@(posedge clk_i) disable iff (!rst_ni)
        tag_count == inflight);

endmodule

// File: tb/tb_if0_fetch.sv
// tb/tb_if0_fetch.sv - self-checking bench for if0_fetch with a randomized memory model
module tb_if0_fetch;
    import if0_fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [31:0] XOR_KEY = 32'hFFFF_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_allow_i = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [31:0] mq_addr [$];
    int          mq_due [$];

    int          obs_cyc;
    logic        obs_req, obs_grant, obs_valid, obs_xfer, obs_rvalid;
    logic [31:0] obs_addr, obs_pc, obs_inst;
    logic [31:0] exp_pc, exp_addr;

    always #5 clk_i = ~clk_i;

    if0_fetch #(.DEPTH(DEPTH)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .if_valid_o       (if_valid_o),
        .if_pc_o          (if_pc_o),
        .if_inst_o        (if_inst_o),
        .if_allow_i       (if_allow_i)
    );

    // One clock: drive inputs at negedge, sample 1ns later, model the in-order memory
    task automatic run_cycle(input logic redir, input logic [31:0] tgt, input logic allow,
                             input logic gnt, input int dmin, input int dmax);
        int due;
        @(negedge clk_i);
        redirect_valid_i = redir;
        redirect_pc_i = tgt;
        if_allow_i = allow;
        imem_gnt_i = gnt;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i = mq_addr[0] ^ XOR_KEY;
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i = $urandom;
        end
        #1;
        obs_cyc = cyc;
        obs_req = imem_req_o;
        obs_addr = imem_addr_o;
        obs_grant = imem_req_o & gnt;
        obs_valid = if_valid_o;
        obs_pc = if_pc_o;
        obs_inst = if_inst_o;
        obs_xfer = if_valid_o & allow & !redir;
        obs_rvalid = imem_rvalid_i;
        if (imem_rvalid_i) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (obs_grant) begin
            due = cyc + 1 + int'($urandom_range(dmax, dmin));
            if (mq_due.size() > 0 && due < mq_due[mq_due.size()-1]) due = mq_due[mq_due.size()-1];
            mq_addr.push_back(obs_addr);
            mq_due.push_back(due);
        end
        @(posedge clk_i);
        cyc++;
    endtask

    // Let every outstanding response return and the output buffer empty
    task automatic drain();
        for (int i = 0; i < 14; i++) run_cycle(1'b0, '0, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        n_checks++; if (if_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", if_valid_o); end
        n_checks++; if (if_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", if_pc_o); end
        n_checks++; if (if_inst_o !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h expected 0", if_inst_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        n_checks++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL reset_req: got %b expected 1", imem_req_o); end
        n_checks++; if (imem_addr_o !== LOONG_PC_START_ADDR) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", imem_addr_o, LOONG_PC_START_ADDR); end
        @(posedge clk_i);
    endtask

    task automatic test_stream();
        int first_g, first_v, ng, nx;
        exp_addr = LOONG_PC_START_ADDR;
        exp_pc = LOONG_PC_START_ADDR;
        first_g = -1; first_v = -1; ng = 0; nx = 0;
        for (int i = 0; i < 12; i++) begin
            run_cycle(1'b0, '0, 1'b1, 1'b1, 0, 0);
            if (obs_grant) begin
                n_checks++; if (obs_addr !== exp_addr) begin n_fail++; $display("FAIL stream_addr: got %h expected %h", obs_addr, exp_addr); end
                exp_addr = exp_addr + 4;
                ng++;
                if (first_g < 0) first_g = obs_cyc;
            end
            if (obs_valid && first_v < 0) first_v = obs_cyc;
            if (obs_xfer) begin
                n_checks++; if (obs_pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc: got %h expected %h", obs_pc, exp_pc); end
                n_checks++; if (obs_inst !== (exp_pc ^ XOR_KEY)) begin n_fail++; $display("FAIL stream_inst: got %h expected %h", obs_inst, exp_pc ^ XOR_KEY); end
                exp_pc = exp_pc + 4;
                nx++;
            end
        end
        n_checks++; if (first_v - first_g != 2) begin n_fail++; $display("FAIL stream_latency: got %0d expected 2", first_v - first_g); end
        n_checks++; if (ng != 12) begin n_fail++; $display("FAIL stream_grants: got %0d expected 12", ng); end
        n_checks++; if (nx != 10) begin n_fail++; $display("FAIL stream_throughput: got %0d expected 10", nx); end
    endtask

    task automatic test_backpressure();
        int ng, nx;
        logic [31:0] a;
        a = 32'h1C00_0400;
        drain();
        run_cycle(1'b1, a, 1'b1, 1'b1, 0, 0);
        exp_pc = a; exp_addr = a; ng = 0; nx = 0;
        for (int i = 0; i < 10; i++) begin
            run_cycle(1'b0, '0, 1'b0, 1'b1, 0, 0);
            if (obs_grant) begin
                n_checks++; if (obs_addr !== exp_addr) begin n_fail++; $display("FAIL bp_addr: got %h expected %h", obs_addr, exp_addr); end
                exp_addr = exp_addr + 4;
                ng++;
            end
        end
        n_checks++; if (ng != DEPTH) begin n_fail++; $display("FAIL bp_grants: got %0d expected %0d", ng, DEPTH); end
        n_checks++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_low: got %b expected 0", obs_req); end
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b0, '0, 1'b1, 1'b1, 0, 0);
            if (obs_xfer) begin
                n_checks++; if (obs_pc !== exp_pc) begin n_fail++; $display("FAIL bp_pc: got %h expected %h", obs_pc, exp_pc); end
                n_checks++; if (obs_inst !== (exp_pc ^ XOR_KEY)) begin n_fail++; $display("FAIL bp_inst: got %h expected %h", obs_inst, exp_pc ^ XOR_KEY); end
                exp_pc = exp_pc + 4;
                nx++;
            end
        end
        n_checks++; if (nx < DEPTH) begin n_fail++; $display("FAIL bp_delivered: got %0d expected at least %0d", nx, DEPTH); end
    endtask

    task automatic test_redirect_inflight();
        int n_rv, got;
        logic [31:0] t;
        t = 32'h1C00_0100;
        drain();
        run_cycle(1'b0, '0, 1'b1, 1'b1, 3, 3);
        run_cycle(1'b0, '0, 1'b1, 1'b1, 3, 3);
        run_cycle(1'b1, t, 1'b1, 1'b1, 0, 0);
        exp_pc = t; n_rv = 0; got = 0;
        for (int i = 0; i < 24; i++) begin
            run_cycle(1'b0, '0, 1'b1, 1'b1, 0, 0);
            if (i == 0) begin
                n_checks++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got %b expected 0", obs_valid); end
                n_checks++; if (obs_req !== 1'b1 || obs_addr !== t) begin n_fail++; $display("FAIL redir_first_req: got req %b addr %h expected 1 %h", obs_req, obs_addr, t); end
            end
            if (obs_xfer) begin
                if (got == 0) begin
                    n_checks++; if (n_rv != 3) begin n_fail++; $display("FAIL redir_dropped: got %0d responses before target expected 3", n_rv); end
                end
                n_checks++; if (obs_pc !== exp_pc) begin n_fail++; $display("FAIL redir_pc: got %h expected %h", obs_pc, exp_pc); end
                n_checks++; if (obs_inst !== (exp_pc ^ XOR_KEY)) begin n_fail++; $display("FAIL redir_inst: got %h expected %h", obs_inst, exp_pc ^ XOR_KEY); end
                exp_pc = exp_pc + 4;
                got++;
            end
            if (obs_rvalid && got == 0) n_rv++;
        end
        n_checks++; if (got < 4) begin n_fail++; $display("FAIL redir_delivered: got %0d expected at least 4", got); end
    endtask

    task automatic test_double_redirect();
        int got;
        drain();
        run_cycle(1'b0, '0, 1'b1, 1'b1, 1, 1);
        run_cycle(1'b0, '0, 1'b1, 1'b1, 1, 1);
        run_cycle(1'b1, 32'h0000_1000, 1'b1, 1'b1, 0, 0);
        run_cycle(1'b1, 32'h0000_2000, 1'b1, 1'b1, 0, 0);
        exp_pc = 32'h0000_2000; got = 0;
        for (int i = 0; i < 16; i++) begin
            run_cycle(1'b0, '0, 1'b1, 1'b1, 0, 2);
            if (obs_xfer) begin
                n_checks++; if (obs_pc !== exp_pc) begin n_fail++; $display("FAIL dbl_pc: got %h expected %h", obs_pc, exp_pc); end
                n_checks++; if (obs_inst !== (exp_pc ^ XOR_KEY)) begin n_fail++; $display("FAIL dbl_inst: got %h expected %h", obs_inst, exp_pc ^ XOR_KEY); end
                exp_pc = exp_pc + 4;
                got++;
            end
        end
        n_checks++; if (got < 4) begin n_fail++; $display("FAIL dbl_delivered: got %0d expected at least 4", got); end
    endtask

    task automatic test_wrap();
        int got;
        drain();
        run_cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 0, 0);
        exp_pc = 32'hFFFF_FFFC; exp_addr = 32'hFFFF_FFFC; got = 0;
        for (int i = 0; i < 10; i++) begin
            run_cycle(1'b0, '0, 1'b1, 1'b1, 0, 0);
            if (obs_grant) begin
                n_checks++; if (obs_addr !== exp_addr) begin n_fail++; $display("FAIL wrap_addr: got %h expected %h", obs_addr, exp_addr); end
                exp_addr = exp_addr + 4;
            end
            if (obs_xfer) begin
                n_checks++; if (obs_pc !== exp_pc) begin n_fail++; $display("FAIL wrap_pc: got %h expected %h", obs_pc, exp_pc); end
                n_checks++; if (obs_inst !== (exp_pc ^ XOR_KEY)) begin n_fail++; $display("FAIL wrap_inst: got %h expected %h", obs_inst, exp_pc ^ XOR_KEY); end
                exp_pc = exp_pc + 4;
                got++;
            end
        end
        n_checks++; if (got < 2) begin n_fail++; $display("FAIL wrap_delivered: got %0d expected at least 2", got); end
    endtask

    task automatic test_random();
        int nx;
        logic redir, allow, gnt;
        logic [31:0] tgt;
        nx = 0;
        for (int i = 0; i < 10000; i++) begin
            redir = (i == 0) || ($urandom_range(31, 0) == 0);
            tgt = $urandom & 32'hFFFF_FFFC;
            allow = ($urandom_range(3, 0) != 0);
            gnt = ($urandom_range(3, 0) != 0);
            run_cycle(redir, tgt, allow, gnt, 0, 5);
            if (redir) begin
                n_checks++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL rnd_req_in_redirect: got %b expected 0", obs_req); end
                exp_pc = tgt;
                exp_addr = tgt;
            end else begin
                if (obs_grant) begin
                    n_checks++; if (obs_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_addr: got %h expected %h", obs_addr, exp_addr); end
                    exp_addr = exp_addr + 4;
                end
                if (obs_xfer) begin
                    n_checks++; if (obs_pc !== exp_pc) begin n_fail++; $display("FAIL rnd_pc: got %h expected %h", obs_pc, exp_pc); end
                    n_checks++; if (obs_inst !== (exp_pc ^ XOR_KEY)) begin n_fail++; $display("FAIL rnd_inst: got %h expected %h", obs_inst, exp_pc ^ XOR_KEY); end
                    exp_pc = exp_pc + 4;
                    nx++;
                end
            end
            n_checks++; if (mq_addr.size() > DEPTH) begin n_fail++; $display("FAIL rnd_inflight: got %0d expected at most %0d", mq_addr.size(), DEPTH); end
        end
        n_checks++; if (nx < 1000) begin n_fail++; $display("FAIL rnd_progress: got %0d expected at least 1000", nx); end
    endtask

    task automatic test_async_reset();
        int got;
        for (int i = 0; i < 6; i++) run_cycle(1'b0, '0, 1'b0, 1'b1, 0, 0);
        n_checks++; if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL arst_prefill: got %b expected 1", obs_valid); end
        #2;
        rst_ni = 1'b0;
        redirect_valid_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; if_allow_i = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        #1;
        n_checks++; if (if_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b expected 0", if_valid_o); end
        n_checks++; if (imem_addr_o !== LOONG_PC_START_ADDR) begin n_fail++; $display("FAIL arst_addr: got %h expected %h", imem_addr_o, LOONG_PC_START_ADDR); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        cyc++;
        exp_pc = LOONG_PC_START_ADDR; got = 0;
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b0, '0, 1'b1, 1'b1, 0, 0);
            if (obs_xfer) begin
                n_checks++; if (obs_pc !== exp_pc) begin n_fail++; $display("FAIL arst_pc: got %h expected %h", obs_pc, exp_pc); end
                exp_pc = exp_pc + 4;
                got++;
            end
        end
        n_checks++; if (got != 6) begin n_fail++; $display("FAIL arst_delivered: got %0d expected 6", got); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_double_redirect();
        test_wrap();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
